// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU control sequencer: control codes,
// ALUOp classes, R-type funct values and FSM state encoding.
package alu_ctrl_pkg;

  localparam logic [3:0] C_AND  = 4'd0;
  localparam logic [3:0] C_OR   = 4'd1;
  localparam logic [3:0] C_ADD  = 4'd2;
  localparam logic [3:0] C_SUB  = 4'd3;
  localparam logic [3:0] C_SLT  = 4'd4;
  localparam logic [3:0] C_XOR  = 4'd7;
  localparam logic [3:0] C_NOR  = 4'd8;
  localparam logic [3:0] C_SLL  = 4'd9;
  localparam logic [3:0] C_SRL  = 4'd10;
  localparam logic [3:0] C_MULT = 4'd11;
  localparam logic [3:0] C_NOP  = 4'd12;
  localparam logic [3:0] C_LUI  = 4'd13;
  localparam logic [3:0] C_DIV  = 4'd14;

  localparam int AOP_R     = 1;
  localparam int AOP_ADDI  = 2;
  localparam int AOP_SLTI  = 3;
  localparam int AOP_XORI  = 4;
  localparam int AOP_NORI  = 5;
  localparam int AOP_SLLI  = 6;
  localparam int AOP_SRLI  = 7;
  localparam int AOP_LOAD  = 8;
  localparam int AOP_STORE = 9;
  localparam int AOP_NOP   = 10;
  localparam int AOP_LUI   = 11;

  localparam int F_ADD  = 32;
  localparam int F_SUB  = 34;
  localparam int F_AND  = 36;
  localparam int F_OR   = 37;
  localparam int F_SLT  = 42;
  localparam int F_MULT = 24;
  localparam int F_DIV  = 26;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_MULTI = 1'b1
  } state_e;

endpackage

// File: rtl/alu_ctrl_seq_if.sv
// Request/response bundle of the ALU control sequencer.
// master = requester (decode stage), slave = sequencer side.
interface alu_ctrl_seq_if #(
  parameter int FUNCT_W = 6,
  parameter int ALUOP_W = 4,
  parameter int CTRL_W  = 4
);
  logic               valid;
  logic [FUNCT_W-1:0] funct;
  logic [ALUOP_W-1:0] aluop;
  logic               flush;
  logic               ready;
  logic [CTRL_W-1:0]  ctrl;
  logic               ctrl_valid;
  logic               busy;
  logic               done;
  logic               err;

  modport master (
    output valid, funct, aluop, flush,
    input  ready, ctrl, ctrl_valid,
    input  busy, done, err
  );

  modport slave (
    input  valid, funct, aluop, flush,
    output ready, ctrl, ctrl_valid,
    output busy, done, err
  );
endinterface

// File: rtl/alu_ctrl_decode.sv
// Combinational ALUOp/funct -> ALU control code decoder.
// Define ALU_CTRL_DIV_EN to decode funct 26 as multi-cycle DIV.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
#(
  parameter int FUNCT_W = 6,
  parameter int ALUOP_W = 4,
  parameter int CTRL_W  = 4
) (
  input  logic [FUNCT_W-1:0] funct_i,
  input  logic [ALUOP_W-1:0] aluop_i,
  output logic [CTRL_W-1:0]  code_o,
  output logic               is_multi_o,
  output logic               illegal_o
);

  logic [3:0] r_code;
  logic       r_multi;
  logic       r_ill;
  logic [3:0] code;

  always_comb begin
    r_code  = C_NOP;
    r_multi = 1'b0;
    r_ill   = 1'b0;
    unique case (1'b1)
      (funct_i == FUNCT_W'(F_ADD)): r_code = C_ADD;
      (funct_i == FUNCT_W'(F_SUB)): r_code = C_SUB;
      (funct_i == FUNCT_W'(F_AND)): r_code = C_AND;
      (funct_i == FUNCT_W'(F_OR)):  r_code = C_OR;
      (funct_i == FUNCT_W'(F_SLT)): r_code = C_SLT;
      (funct_i == FUNCT_W'(F_MULT)): begin
        r_code  = C_MULT;
        r_multi = 1'b1;
      end
`ifdef ALU_CTRL_DIV_EN
      (funct_i == FUNCT_W'(F_DIV)): begin
        r_code  = C_DIV;
        r_multi = 1'b1;
      end
`endif
      default: r_ill = 1'b1;
    endcase
  end

  always_comb begin
    code       = C_NOP;
    is_multi_o = 1'b0;
    illegal_o  = 1'b0;
    unique case (1'b1)
      (aluop_i == ALUOP_W'(AOP_R)): begin
        code       = r_code;
        is_multi_o = r_multi;
        illegal_o  = r_ill;
      end
      (aluop_i == ALUOP_W'(AOP_ADDI)),
      (aluop_i == ALUOP_W'(AOP_LOAD)),
      (aluop_i == ALUOP_W'(AOP_STORE)):
        code = C_ADD;
      (aluop_i == ALUOP_W'(AOP_SLTI)): code = C_SLT;
      (aluop_i == ALUOP_W'(AOP_XORI)): code = C_XOR;
      (aluop_i == ALUOP_W'(AOP_NORI)): code = C_NOR;
      (aluop_i == ALUOP_W'(AOP_SLLI)): code = C_SLL;
      (aluop_i == ALUOP_W'(AOP_SRLI)): code = C_SRL;
      (aluop_i == ALUOP_W'(AOP_NOP)):  code = C_NOP;
      (aluop_i == ALUOP_W'(AOP_LUI)):  code = C_LUI;
      default: code = C_NOP;
    endcase
  end

  assign code_o = CTRL_W'(code);

endmodule

// File: rtl/alu_ctrl_seq.sv
// ALU control sequencer: registered decode with multi-cycle MULT/DIV.
// Define ALU_CTRL_DIV_EN to enable the DIV_LAT-cycle DIV operation.
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int FUNCT_W = 6,
  parameter int ALUOP_W = 4,
  parameter int CTRL_W  = 4,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               valid_i,
  input  logic [FUNCT_W-1:0] funct_i,
  input  logic [ALUOP_W-1:0] ALUOp_i,
  input  logic               flush_i,
  output logic               ready_o,
  output logic [CTRL_W-1:0]  ALUCtrl_o,
  output logic               ctrl_valid_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o
);

  localparam int MAX_LAT =
    (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W = $clog2(MAX_LAT + 1);
  localparam logic [CNT_W-1:0] MUL_LD =
    CNT_W'(MUL_LAT - 1);
`ifdef ALU_CTRL_DIV_EN
  localparam logic [CNT_W-1:0] DIV_LD =
    CNT_W'(DIV_LAT - 1);
`endif

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              cvalid_q, cvalid_d;
  logic              err_q, err_d;

  logic [CTRL_W-1:0] dec_code;
  logic              dec_multi;
  logic              dec_ill;
  logic              ready;
  logic              accept;
  logic [CNT_W-1:0]  cnt_ld;

  alu_ctrl_decode #(
    .FUNCT_W (FUNCT_W),
    .ALUOP_W (ALUOP_W),
    .CTRL_W  (CTRL_W)
  ) u_dec (
    .funct_i    (funct_i),
    .aluop_i    (ALUOp_i),
    .code_o     (dec_code),
    .is_multi_o (dec_multi),
    .illegal_o  (dec_ill)
  );

  assign ready  = (state_q == S_IDLE) && !flush_i;
  assign accept = valid_i && ready;

`ifdef ALU_CTRL_DIV_EN
  assign cnt_ld = (dec_code == CTRL_W'(C_DIV)) ?
                  DIV_LD : MUL_LD;
`else
  assign cnt_ld = MUL_LD;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Flush wins over everything, including a same-cycle request.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else if (state_q == S_MULTI) begin
      if (cnt_q == '0) state_d = S_IDLE;
      else             cnt_d   = cnt_q - 1'b1;
    end else if (accept && dec_multi) begin
      state_d = S_MULTI;
      cnt_d   = cnt_ld;
    end
  end

  always_comb begin
    ctrl_d   = ctrl_q;
    cvalid_d = 1'b0;
    err_d    = 1'b0;
    if (flush_i) begin
      ctrl_d = CTRL_W'(C_NOP);
    end else if (state_q == S_MULTI) begin
      cvalid_d = (cnt_q != '0);
    end else if (accept) begin
      ctrl_d   = dec_code;
      cvalid_d = 1'b1;
      err_d    = dec_ill;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ctrl_q   <= CTRL_W'(C_NOP);
      cvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      ctrl_q   <= ctrl_d;
      cvalid_q <= cvalid_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    ready_o      = ready;
    ALUCtrl_o    = ctrl_q;
    ctrl_valid_o = cvalid_q;
    err_o        = err_q;
    busy_o       = (state_q == S_MULTI);
    done_o       = busy_o && (cnt_q == '0) && !flush_i;
  end

endmodule
